// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - 8-entry FIFO controller driving an external 8x6 memory; optional FIFO_CTRL_ERR_EN adds sticky overflow/underflow
module fifo_ctrl #(
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       push,
  input  logic [5:0] push_data,
  input  logic       pop,
  output logic [5:0] pop_data,
  output logic       pop_valid,
  output logic       ready,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic [3:0] count,
  output logic       mem_write,
  output logic       mem_read,
  output logic [2:0] mem_address_write,
  output logic [2:0] mem_address_read,
  output logic [5:0] mem_data,
  input  logic [5:0] mem_data_out
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic       overflow,
  output logic       underflow
`endif
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] AF_LVL = AF_LEVEL[3:0];
  localparam logic [3:0] AE_LVL = AE_LEVEL[3:0];

  state_t     state_q, state_d;
  logic [2:0] init_idx_q, init_idx_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic       pop_valid_q, pop_valid_d;
  logic [2:0] addr_wr_q, addr_wr_d;
  logic [2:0] addr_rd_q, addr_rd_d;
  logic [5:0] wdata_q, wdata_d;
  logic       wr_stb, rd_stb;
  logic       push_ok, pop_ok;
  logic       full_w, empty_w;

  // Occupancy flags come straight from the registered count.
  assign full_w  = (count_q == 4'd8);
  assign empty_w = (count_q == 4'd0);

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: only reset clears them; INIT never sets them.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (state_q == ST_RUN) begin
      if (push && full_w) overflow_d = 1'b1;
      if (pop && empty_w) underflow_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // Next-state logic: INIT sweeps zeros through memory, RUN services push/pop.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_wr_d   = addr_wr_q;
    addr_rd_d   = addr_rd_q;
    wdata_d     = wdata_q;
    wr_stb      = 1'b0;
    rd_stb      = 1'b0;
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    pop_valid_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        wr_stb     = 1'b1;
        addr_wr_d  = init_idx_q;
        wdata_d    = 6'd0;
        init_idx_d = init_idx_q + 3'd1;
        if (init_idx_q == 3'd7) state_d = ST_RUN;
      end
      default: begin
        // No bypass: a pop on empty or a push on full is simply dropped.
        push_ok = push && !full_w;
        pop_ok  = pop && !empty_w;
        if (push_ok) begin
          wr_stb    = 1'b1;
          addr_wr_d = wr_ptr_q;
          wdata_d   = push_data;
          wr_ptr_d  = wr_ptr_q + 3'd1;
        end
        if (pop_ok) begin
          rd_stb    = 1'b1;
          addr_rd_d = rd_ptr_q;
          rd_ptr_d  = rd_ptr_q + 3'd1;
        end
        pop_valid_d = pop_ok;
        case ({push_ok, pop_ok})
          2'b10:   count_d = count_q + 4'd1;
          2'b01:   count_d = count_q - 4'd1;
          default: count_d = count_q;
        endcase
      end
    endcase
  end

  // State registers; synchronous reset restarts the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= ST_INIT;
      init_idx_q  <= 3'd0;
      wr_ptr_q    <= 3'd0;
      rd_ptr_q    <= 3'd0;
      count_q     <= 4'd0;
      pop_valid_q <= 1'b0;
      addr_wr_q   <= 3'd0;
      addr_rd_q   <= 3'd0;
      wdata_q     <= 6'd0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      addr_wr_q   <= addr_wr_d;
      addr_rd_q   <= addr_rd_d;
      wdata_q     <= wdata_d;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign mem_write         = wr_stb && !RESET;
  assign mem_read          = rd_stb && !RESET;
  assign mem_address_write = RESET ? 3'd0 : addr_wr_d;
  assign mem_address_read  = RESET ? 3'd0 : addr_rd_d;
  assign mem_data          = RESET ? 6'd0 : wdata_d;
  assign ready             = !RESET && (state_q == ST_RUN);
  assign count             = RESET ? 4'd0 : count_q;
  assign full              = !RESET && full_w;
  assign empty             = RESET || empty_w;
  assign almost_full       = !RESET && (count_q >= AF_LVL);
  assign almost_empty      = RESET || (count_q <= AE_LVL);
  assign pop_valid         = pop_valid_q;
  assign pop_data          = mem_data_out;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - randomized scoreboard bench for fifo_ctrl with queue-based reference model
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       push = 1'b0;
  logic [5:0] push_data = 6'd0;
  logic       pop = 1'b0;
  logic [5:0] pop_data;
  logic       pop_valid, ready, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       mem_write, mem_read;
  logic [2:0] mem_address_write, mem_address_read;
  logic [5:0] mem_data;
  logic [5:0] mem_data_out = 6'd0;
`ifdef FIFO_CTRL_ERR_EN
  logic       overflow, underflow;
`endif

  fifo_ctrl #(.AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .RESET(RESET), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .ready(ready), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .mem_write(mem_write), .mem_read(mem_read),
    .mem_address_write(mem_address_write), .mem_address_read(mem_address_read),
    .mem_data(mem_data), .mem_data_out(mem_data_out)
`ifdef FIFO_CTRL_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // External 8x6 memory: synchronous write, registered read.
  logic [5:0] mem [8];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address_write] <= mem_data;
    if (mem_read) mem_data_out <= mem[mem_address_read];
  end

  int total = 0;
  int bad = 0;
  int m_q[$];
  int exp_q[$];
  int m_wr, m_rd;
  int last_wa, last_ra, last_wd;
  bit m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every presented pop_valid consumes one expected word.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_valid_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One RUN cycle: drive, check same-cycle strobes against the model, advance.
  task automatic step(input bit p, input logic [5:0] d, input bit q);
    bit pa, qa;
    int n;
    push = p; push_data = d; pop = q;
    #1;
    n  = m_q.size();
    pa = p && (n < 8);
    qa = q && (n > 0);
    chk("ready", 32'(ready), 32'(1));
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("mem_write", 32'(mem_write), 32'(pa));
    chk("mem_read", 32'(mem_read), 32'(qa));
    if (pa) begin last_wa = m_wr; last_wd = int'(d); end
    if (qa) last_ra = m_rd;
    chk("mem_address_write", 32'(mem_address_write), 32'(last_wa));
    chk("mem_data", 32'(mem_data), 32'(last_wd));
    chk("mem_address_read", 32'(mem_address_read), 32'(last_ra));
    if (p && !pa) m_ovf = 1'b1;
    if (q && !qa) m_unf = 1'b1;
    if (qa) begin exp_q.push_back(m_q.pop_front()); m_rd = (m_rd + 1) % 8; end
    if (pa) begin m_q.push_back(int'(d)); m_wr = (m_wr + 1) % 8; end
    @(posedge clk); #1;
    chk("pop_valid", 32'(pop_valid), 32'(qa));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  // Reset for cyc edges, then check the 8-cycle zero sweep with push/pop held high.
  task automatic do_reset(input int cyc);
    RESET = 1'b1; push = 1'b0; pop = 1'b0;
    repeat (cyc) begin
      @(posedge clk); #1;
      chk("rst_mem_write", 32'(mem_write), 32'(0));
      chk("rst_mem_read", 32'(mem_read), 32'(0));
      chk("rst_addr_w", 32'(mem_address_write), 32'(0));
      chk("rst_addr_r", 32'(mem_address_read), 32'(0));
      chk("rst_mem_data", 32'(mem_data), 32'(0));
      chk("rst_ready", 32'(ready), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_almost_empty", 32'(almost_empty), 32'(1));
      chk("rst_full", 32'(full), 32'(0));
      chk("rst_almost_full", 32'(almost_full), 32'(0));
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_pop_valid", 32'(pop_valid), 32'(0));
    end
    chk("pending_before_reset", 32'(exp_q.size()), 32'(0));
    m_q.delete(); exp_q.delete();
    m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_unf = 1'b0;
    RESET = 1'b0; push = 1'b1; pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_data = 6'($urandom);
      #1;
      chk("init_mem_write", 32'(mem_write), 32'(1));
      chk("init_addr", 32'(mem_address_write), 32'(i));
      chk("init_data", 32'(mem_data), 32'(0));
      chk("init_ready", 32'(ready), 32'(0));
      chk("init_mem_read", 32'(mem_read), 32'(0));
      chk("init_count", 32'(count), 32'(0));
      @(posedge clk);
    end
    push = 1'b0; pop = 1'b0;
    #1;
    last_wa = 7; last_wd = 0; last_ra = 0;
    chk("post_init_ready", 32'(ready), 32'(1));
    chk("post_init_empty", 32'(empty), 32'(1));
    chk("post_init_count", 32'(count), 32'(0));
    chk("post_init_mem_write", 32'(mem_write), 32'(0));
    for (int i = 0; i < 8; i++) chk("mem_cleared", 32'(mem[i]), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pp, qp;
    do_reset(2);
    // Fill to full, then a dropped 9th push.
    for (int i = 1; i <= 8; i++) step(1'b1, 6'(i), 1'b0);
    step(1'b1, 6'd9, 1'b0);
    // Drain in order, then a dropped 9th pop.
    repeat (9) step(1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 1'b0);
    // Pointer wrap: park both pointers at 7, push 0xC and 0xB, pop 0xC.
    do_reset(2);
    repeat (7) step(1'b1, 6'($urandom), 1'b0);
    repeat (7) step(1'b0, 6'd0, 1'b1);
    step(1'b1, 6'hC, 1'b0);
    step(1'b1, 6'hB, 1'b0);
    step(1'b0, 6'd0, 1'b1);
    step(1'b1, 6'($urandom), 1'b0);
    repeat (3) step(1'b0, 6'd0, 1'b1);
    // Simultaneous push/pop at empty, full and half.
    do_reset(1);
    step(1'b1, 6'($urandom), 1'b1);
    step(1'b0, 6'd0, 1'b1);
    repeat (8) step(1'b1, 6'($urandom), 1'b0);
    step(1'b1, 6'($urandom), 1'b1);
    step(1'b1, 6'($urandom), 1'b0);
    repeat (4) step(1'b0, 6'd0, 1'b1);
    step(1'b1, 6'($urandom), 1'b1);
    // Reset with five entries held.
    step(1'b1, 6'($urandom), 1'b0);
    step(1'b0, 6'd0, 1'b0);
    do_reset(1);
    // Randomized traffic in phases of differing push/pop bias.
    for (int ph = 0; ph < 4; ph++) begin
      pp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      qp = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 90;
      repeat (150) step($urandom_range(0, 99) < pp, 6'($urandom), $urandom_range(0, 99) < qp);
    end
    step(1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 1'b0);
    chk("outstanding_pops", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter AF_LEVEL, default 6, SHALL set the almost-full threshold: almost_full is 1 when count >= AF_LEVEL.
REQ-002 Parameter AE_LEVEL, default 2, SHALL set the almost-empty threshold: almost_empty is 1 when count <= AE_LEVEL.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 push  input  1  write request from the producer.
REQ-006 push_data  input  6  data to write.
REQ-007 pop  input  1  read request from the consumer.
REQ-008 pop_data  output  6  read data, driven from mem_data_out.
REQ-009 pop_valid  output  1  registered; 1 in the cycle pop_data is valid.
REQ-010 ready  output  1  1 when the controller is in RUN.
REQ-011 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-012 count  output  4  occupancy, 0..8.
REQ-013 mem_write, mem_read  output  1 each  strobes to the 8x6 memory.
REQ-014 mem_address_write, mem_address_read  output  3 each  memory addresses.
REQ-015 mem_data  output  6  memory write data.
REQ-016 mem_data_out  input  6  memory read data, valid one cycle after mem_read.

Function
REQ-017 The FSM SHALL have two states, INIT and RUN.
REQ-018 INIT SHALL clear the memory: it writes 0 to addresses 0..7 on 8 consecutive cycles, then moves to RUN.
REQ-019 In INIT: ready=0, push and pop ignored, mem_read=0.
REQ-020 In RUN, a push with full=0 SHALL be accepted in the same cycle: mem_write=1, mem_address_write=wr_ptr, mem_data=push_data; wr_ptr increments.
REQ-021 In RUN, a pop with empty=0 SHALL be accepted in the same cycle: mem_read=1, mem_address_read=rd_ptr; rd_ptr increments.
REQ-022 After an accepted pop, pop_valid SHALL be 1 on the next cycle with pop_data=mem_data_out, giving 1-cycle latency.
REQ-023 Push when full SHALL be dropped: mem_write=0, pointers and count unchanged.
REQ-024 Pop when empty SHALL be dropped: mem_read=0 and pop_valid=0 on the next cycle.
REQ-025 Simultaneous push and pop, neither full nor empty: both SHALL be accepted and count stays unchanged.
REQ-026 Simultaneous push and pop when empty: only the push is accepted (no bypass) and count becomes 1.
REQ-027 Simultaneous push and pop when full: only the pop is accepted and count becomes 7.
REQ-028 Pointers are 3 bits and SHALL wrap from 7 to 0.
REQ-029 count SHALL be exact, 0..8; full = (count==8), empty = (count==0); all flags are derived from registered count.
REQ-030 When no request is accepted, mem_write and mem_read SHALL be 0 and the address and data outputs hold their previous values.

Reset
REQ-031 With RESET=1 at a clock edge, the block SHALL enter INIT and clear wr_ptr, rd_ptr, count, the INIT index and pop_valid.
REQ-032 During reset: mem_write=0, mem_read=0, addresses=0, mem_data=0, ready=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL discard all contents and restart the INIT sequence from address 0.

Configuration
REQ-034 With macro FIFO_CTRL_ERR_EN defined, the block SHALL add sticky outputs overflow and underflow (1 bit each).
- Set on a dropped push (overflow) or a dropped pop in RUN (underflow).
- Cleared only by RESET.
REQ-035 Without FIFO_CTRL_ERR_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset for 2 cycles then release -> exactly 8 writes of 0 to addresses 0..7, then ready=1, empty=1, count=0.
REQ-037 Push 1..8 on consecutive cycles -> full=1, count=8; almost_full rises after the 6th push; a 9th push of 9 produces no mem_write.
REQ-038 Pop 8 times -> pop_data = 1..8 in order, each 1 cycle after its pop; empty=1; a 9th pop gives pop_valid=0 (underflow=1 if FIFO_CTRL_ERR_EN).
REQ-039 Push 7 and pop 7 to put the pointers at 7, then push 0xC, 0xB -> wr_ptr wraps to 1 and a pop returns 0xC.
REQ-040 Simultaneous push and pop at count=0 -> count=1; at count=8 -> count=7; at count=4 -> count=4 with write and read both strobed.
REQ-041 RESET asserted at count=5 -> the next cycle shows INIT with count=0 and mem_address_write=0, and the 8-cycle clear repeats.
